// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: FSM state encodings, control-bus bit indices and lane-select helper
package dmem_arbiter_pkg;
  typedef enum logic {DMA_FIRST = 1'b0, DMA_SECOND = 1'b1} dma_state_e;
  localparam int MEMREAD = 0;
  localparam int MEMWRITE = 1;
  function automatic logic lane1_sel(input dma_state_e state, input logic req0);
    return (state == DMA_SECOND) || !req0;
  endfunction
endpackage

// File: rtl/dmem_arbiter_lane_mux.sv
// dmem_arbiter_lane_mux: combinational lane select onto the data-memory port
module dmem_arbiter_lane_mux #(
  parameter int ADDR_W = 10
) (
  input  logic              valid,
  input  logic              sel1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        be0,
  input  logic [3:0]        be1,
  output logic              re,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic [3:0]        be
);
  logic [31:0] addr_sel;
  logic        we_sel;
  logic        unused_addr;
  assign addr_sel = sel1 ? addr1 : addr0;
  assign we_sel = sel1 ? we1 : we0;
  assign re = valid && !we_sel;
  assign we = valid && we_sel;
  assign addr = addr_sel[ADDR_W+1:2];
  assign wdata = sel1 ? wdata1 : wdata0;
  assign be = we ? (sel1 ? be1 : be0) : 4'b0000;
  assign unused_addr = ^{addr_sel[31:ADDR_W+2], addr_sel[1:0]};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises the two LSU lanes onto one data-memory port, lane 0 first
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  input  logic [3:0]        be0_i,
  input  logic [3:0]        be1_i,
  input  logic              mem_gnt_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic              mem_stall_o,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,
  output logic [CNT_W-1:0]  conf_cnt_o
);
  dma_state_e  state_q;
  logic        direct0_q, direct1_q, pend0_q;
  logic [31:0] hold_q0;
  logic        second, both, presented, sel1, accept, cnt_inc;
  assign second = state_q == DMA_SECOND;
  assign both = req0_i && req1_i;
  assign presented = !reset_i && (second || req0_i || req1_i);
  assign sel1 = lane1_sel(state_q, req0_i);
  assign accept = presented && mem_gnt_i;
  assign mem_stall_o = presented && (second ? !mem_gnt_i : (!mem_gnt_i || both));
  // conflict stall cycles: the lane-0 half of a dual bundle, plus any wait while lane 1 is pending
  assign cnt_inc = second ? !mem_gnt_i : (both && mem_gnt_i);
  assign rdata0_o = reset_i ? '0 : (direct0_q ? mem_rdata_i : hold_q0);
  assign rdata1_o = (reset_i || !direct1_q) ? '0 : mem_rdata_i;
  dmem_arbiter_lane_mux #(.ADDR_W(ADDR_W)) u_lane_mux (
    .valid(presented),
    .sel1(sel1),
    .we0(we0_i),
    .we1(we1_i),
    .addr0(addr0_i),
    .addr1(addr1_i),
    .wdata0(wdata0_i),
    .wdata1(wdata1_i),
    .be0(be0_i),
    .be1(be1_i),
    .re(mem_re_o),
    .we(mem_we_o),
    .addr(mem_addr_o),
    .wdata(mem_wdata_o),
    .be(mem_be_o)
  );
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= DMA_FIRST;
      direct0_q <= 1'b0;
      direct1_q <= 1'b0;
      pend0_q <= 1'b0;
      hold_q0 <= '0;
      conf_cnt_o <= '0;
    end else begin
      state_q <= (accept && !second && both) ? DMA_SECOND : (accept ? DMA_FIRST : state_q);
      direct0_q <= accept && !sel1 && !both && !we0_i;
      pend0_q <= accept && !sel1 && both && !we0_i;
      direct1_q <= accept && sel1 && !we1_i;
      if (pend0_q) hold_q0 <= mem_rdata_i;
      if (cnt_inc && conf_cnt_o != '1) conf_cnt_o <= conf_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tasks with hand-computed expectations
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int CNT_W = 4;
  logic              clock_i = 1'b0;
  logic              reset_i, req0_i, req1_i, we0_i, we1_i, mem_gnt_i;
  logic [31:0]       addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i;
  logic [3:0]        be0_i, be1_i;
  logic              mem_re_o, mem_we_o, mem_stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o, rdata0_o, rdata1_o;
  logic [3:0]        mem_be_o;
  logic [CNT_W-1:0]  conf_cnt_o;
  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .be0_i(be0_i), .be1_i(be1_i), .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_stall_o(mem_stall_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .conf_cnt_o(conf_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle();
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
    addr0_i = 0; addr1_i = 0; wdata0_i = 0; wdata1_i = 0;
    be0_i = 0; be1_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; idle(); req0_i = 1; addr0_i = 32'h40; mem_gnt_i = 1;
    step(); step(); #4;
    checks++; if ({mem_re_o, mem_we_o, mem_stall_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {mem_re_o, mem_we_o, mem_stall_o}); end
    checks++; if (conf_cnt_o !== 4'd0 || rdata0_o !== 0 || rdata1_o !== 0) begin errors++; $display("FAIL reset_regs cnt=%0d rd0=%h rd1=%h exp=0", conf_cnt_o, rdata0_o, rdata1_o); end
    step(); reset_i = 0; idle();
  endtask

  task automatic test_single_load();
    req0_i = 1; addr0_i = 32'h40; mem_gnt_i = 1; #4;
    checks++; if ({mem_re_o, mem_we_o, mem_stall_o, mem_addr_o} !== {3'b100, 10'h010}) begin errors++; $display("FAIL single_present re/we/stall/addr got=%b/%h exp=100/010", {mem_re_o, mem_we_o, mem_stall_o}, mem_addr_o); end
    step(); idle(); mem_rdata_i = 32'hDEADBEEF; #4;
    checks++; if (rdata0_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata0 got=%h exp=deadbeef", rdata0_o); end
    step(); idle();
  endtask

  task automatic test_store_load();
    req0_i = 1; we0_i = 1; addr0_i = 32'h80; wdata0_i = 32'h11223344; be0_i = 4'hF;
    req1_i = 1; we1_i = 0; addr1_i = 32'h84; be1_i = 4'h3; mem_gnt_i = 1; #4;
    checks++; if ({mem_re_o, mem_we_o, mem_stall_o, mem_addr_o} !== {3'b011, 10'h020}) begin errors++; $display("FAIL sl_cycle0 re/we/stall/addr got=%b/%h exp=011/020", {mem_re_o, mem_we_o, mem_stall_o}, mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h11223344 || mem_be_o !== 4'hF) begin errors++; $display("FAIL sl_wdata got=%h/%h exp=11223344/f", mem_wdata_o, mem_be_o); end
    step(); #4;
    checks++; if ({mem_re_o, mem_we_o, mem_stall_o, mem_addr_o, mem_be_o} !== {3'b100, 10'h021, 4'h0}) begin errors++; $display("FAIL sl_cycle1 re/we/stall/addr/be got=%b/%h/%h exp=100/021/0", {mem_re_o, mem_we_o, mem_stall_o}, mem_addr_o, mem_be_o); end
    step(); idle(); mem_rdata_i = 32'h00000055; #4;
    checks++; if (rdata1_o !== 32'h55) begin errors++; $display("FAIL sl_rdata1 got=%h exp=55", rdata1_o); end
    checks++; if (conf_cnt_o !== 4'd1) begin errors++; $display("FAIL sl_conf_cnt got=%0d exp=1", conf_cnt_o); end
    step(); idle();
  endtask

  task automatic test_dual_load();
    req0_i = 1; addr0_i = 32'h100; req1_i = 1; addr1_i = 32'h104; mem_gnt_i = 1; #4;
    checks++; if ({mem_re_o, mem_stall_o, mem_addr_o} !== {2'b11, 10'h040}) begin errors++; $display("FAIL dual_cycle0 re/stall/addr got=%b/%h exp=11/040", {mem_re_o, mem_stall_o}, mem_addr_o); end
    step(); mem_rdata_i = 32'hAAAA0001; #4;
    checks++; if ({mem_re_o, mem_stall_o, mem_addr_o} !== {2'b10, 10'h041}) begin errors++; $display("FAIL dual_cycle1 re/stall/addr got=%b/%h exp=10/041", {mem_re_o, mem_stall_o}, mem_addr_o); end
    step(); idle(); mem_rdata_i = 32'hBBBB0002; #4;
    checks++; if (rdata0_o !== 32'hAAAA0001) begin errors++; $display("FAIL dual_rdata0 got=%h exp=aaaa0001", rdata0_o); end
    checks++; if (rdata1_o !== 32'hBBBB0002) begin errors++; $display("FAIL dual_rdata1 got=%h exp=bbbb0002", rdata1_o); end
    checks++; if (conf_cnt_o !== 4'd2) begin errors++; $display("FAIL dual_conf_cnt got=%0d exp=2", conf_cnt_o); end
    step(); idle();
  endtask

  task automatic test_backpressure();
    logic [2:0] stalls;
    logic       lane1_ok;
    req1_i = 1; addr1_i = 32'h200; addr0_i = 32'h3FC; lane1_ok = 1;
    for (int i = 0; i < 3; i++) begin
      mem_gnt_i = (i == 2); #4;
      stalls[i] = mem_stall_o;
      if (mem_addr_o !== 10'h080 || mem_re_o !== 1'b1) lane1_ok = 0;
      step();
    end
    checks++; if (stalls !== 3'b011) begin errors++; $display("FAIL bp_stall_seq got=%b exp=011 (lsb first)", stalls); end
    checks++; if (lane1_ok !== 1'b1) begin errors++; $display("FAIL bp_lane1_presented got=%b exp=1", lane1_ok); end
    idle(); mem_rdata_i = 32'hC0FFEE00; #4;
    checks++; if (rdata1_o !== 32'hC0FFEE00) begin errors++; $display("FAIL bp_rdata1 got=%h exp=c0ffee00", rdata1_o); end
    checks++; if (conf_cnt_o !== 4'd2) begin errors++; $display("FAIL bp_conf_cnt got=%0d exp=2", conf_cnt_o); end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    req0_i = 1; addr0_i = 32'h10; req1_i = 1; addr1_i = 32'h20; mem_gnt_i = 1;
    step(); mem_gnt_i = 0; #4;
    checks++; if (mem_addr_o !== 10'h008 || mem_stall_o !== 1'b1) begin errors++; $display("FAIL mid_second addr/stall got=%h/%b exp=008/1", mem_addr_o, mem_stall_o); end
    reset_i = 1; #1;
    checks++; if ({mem_re_o, mem_we_o, mem_stall_o} !== 3'b000 || rdata0_o !== 0) begin errors++; $display("FAIL mid_in_reset strobes/stall=%b rd0=%h exp=000/0", {mem_re_o, mem_we_o, mem_stall_o}, rdata0_o); end
    step(); reset_i = 0; req1_i = 0; mem_gnt_i = 1; #4;
    checks++; if (conf_cnt_o !== 4'd0) begin errors++; $display("FAIL mid_conf_cnt got=%0d exp=0", conf_cnt_o); end
    checks++; if ({mem_re_o, mem_stall_o, mem_addr_o} !== {2'b10, 10'h004}) begin errors++; $display("FAIL mid_first re/stall/addr got=%b/%h exp=10/004", {mem_re_o, mem_stall_o}, mem_addr_o); end
    step(); idle();
  endtask

  task automatic test_saturate();
    mem_gnt_i = 1;
    for (int b = 0; b < 17; b++) begin
      req0_i = 1; req1_i = 1; addr0_i = 32'h0; addr1_i = 32'h4;
      step(); step(); idle();
      if (b == 14) begin
        #4;
        checks++; if (conf_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", conf_cnt_o); end
      end
    end
    #4;
    checks++; if (conf_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", conf_cnt_o); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store_load();
    test_dual_load();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
